spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, memory address and data width.
REQ-002 Parameter MEM_DEPTH, default 256, number of memory words.
REQ-003 Parameter TX_BEATS, default 8, number of cycles tx_valid is held per read.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rx_data  in  ADDR_SIZE+2  SPI slave frame: [9:8] command, [7:0] payload.
REQ-007 rx_valid  in  1  SPI slave frame-complete level; stays high until SS_n release.
REQ-008 tx_data  out  ADDR_SIZE  read data toward SPI slave.
REQ-009 tx_valid  out  1  tx_data valid toward SPI slave.
REQ-010 host_req  in  1  local host access request; held high until host_gnt.
REQ-011 host_we  in  1  1 = write, 0 = read; sampled with host_req.
REQ-012 host_addr  in  ADDR_SIZE  host address.
REQ-013 host_wdata  in  ADDR_SIZE  host write data.
REQ-014 host_gnt  out  1  one-cycle pulse: host request accepted.
REQ-015 host_rdata  out  ADDR_SIZE  host read data.
REQ-016 host_rvalid  out  1  one-cycle pulse: host_rdata valid.
REQ-017 mem_en, mem_we  out  1 each  single-port memory enable and write enable.
REQ-018 mem_addr, mem_wdata  out  ADDR_SIZE each  memory address and write data.
REQ-019 mem_rdata  in  ADDR_SIZE  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-020 spi_ovf  out  1  sticky: SPI command lost.

Function
REQ-021 Frame accept: a cycle with rx_valid=1 and the registered previous rx_valid=0 (rising edge) SHALL accept exactly one command; a held-high level SHALL NOT re-trigger.
REQ-022 Command 00: latch payload into wr_addr on the accept cycle; no memory access.
REQ-023 Command 10: latch payload into rd_addr on the accept cycle; no memory access.
REQ-024 Command 01: set spi_pend with op=write and data=payload.
REQ-025 Command 11: set spi_pend with op=read; payload ignored.
REQ-026 Command 01/11 accepted while spi_pend=1: new command dropped, spi_pend unchanged, spi_ovf set to 1.
REQ-027 FSM states: IDLE, SPI_WR, SPI_RD, SPI_RDWAIT, HOST_WR, HOST_RD, HOST_RDWAIT.
REQ-028 IDLE: with only spi_pend, go to SPI_WR or SPI_RD per op; with only host_req, go to HOST_WR or HOST_RD per host_we, and pulse host_gnt in that IDLE cycle; otherwise stay in IDLE.
REQ-029 Conflict (spi_pend and host_req in the same IDLE cycle): grant the side not granted last; last_grant resets to host, so SPI wins the first conflict.
REQ-030 SPI_WR: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=payload; clear spi_pend; go to IDLE.
REQ-031 SPI_RD: mem_en=1, mem_we=0, mem_addr=rd_addr; clear spi_pend; go to SPI_RDWAIT.
REQ-032 SPI_RDWAIT: capture mem_rdata into tx_data; load tx_cnt=TX_BEATS; go to IDLE.
REQ-033 tx_valid=1 exactly while tx_cnt!=0; tx_cnt decrements by 1 per cycle, so tx_valid is high for TX_BEATS consecutive cycles starting the cycle after SPI_RDWAIT.
REQ-034 tx_data SHALL hold its value until the next SPI_RDWAIT; a new capture while tx_cnt!=0 reloads tx_cnt and sets spi_ovf.
REQ-035 HOST_WR: mem write of host_wdata to host_addr (registered at grant); go to IDLE.
REQ-036 HOST_RD: mem read at registered host_addr; go to HOST_RDWAIT.
REQ-037 HOST_RDWAIT: host_rdata=mem_rdata; pulse host_rvalid; go to IDLE.
REQ-038 Every non-IDLE state lasts one cycle; mem_en=0 in IDLE and in the *RDWAIT states.
REQ-039 Host serving does not stall the tx_cnt countdown; new frames are accepted in any state.

Reset
REQ-040 On rst_n=0, asynchronously: FSM=IDLE; tx_data, tx_valid, tx_cnt, host_gnt, host_rdata, host_rvalid, mem_en, mem_we, mem_addr, mem_wdata, spi_ovf, spi_pend, wr_addr, rd_addr and previous rx_valid all 0; last_grant=host.
REQ-041 Reset mid-operation SHALL abandon the in-flight access without a memory write after release.

Verification
REQ-042 Frames 00_0x12 then 01_0xAB -> one cycle with mem_en=1, mem_we=1, mem_addr=0x12, mem_wdata=0xAB.
REQ-043 Memory[0x12]=0xAB; frames 10_0x12 then 11_xx -> tx_data=0xAB with tx_valid high for exactly 8 cycles, then 0.
REQ-044 rx_valid held high for 20 cycles after frame 01_0x55 -> exactly one memory write.
REQ-045 spi_pend and host_req in the same IDLE cycle, twice back-to-back -> SPI granted first, host second; host_gnt pulses once.
REQ-046 Second 01 frame before the first is serviced (host holding memory) -> spi_ovf=1 and only the first write occurs.
REQ-047 rst_n pulsed low during SPI_RD -> no tx_valid; all outputs 0; a new read after release completes normally.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Arbitrates one single-port memory between an SPI slave command stream and a local host port.
// SPI frames carry address/data/read commands; a round-robin tie-break resolves simultaneous requests.
module spi_mem_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int TX_BEATS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [ADDR_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [ADDR_SIZE-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [ADDR_SIZE-1:0] mem_wdata,
    input  logic [ADDR_SIZE-1:0] mem_rdata,
    output logic                 spi_ovf
);

    localparam int CNT_W = $clog2(TX_BEATS + 1);
    localparam logic [ADDR_SIZE-1:0] ADDR_MASK = ADDR_SIZE'((2 ** $clog2(MEM_DEPTH)) - 1);
    localparam logic GRANT_HOST = 1'b0;
    localparam logic GRANT_SPI  = 1'b1;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE   = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_READ    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SPI_WR,
        SPI_RD,
        SPI_RDWAIT,
        HOST_WR,
        HOST_RD,
        HOST_RDWAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 spi_pend_q, spi_pend_d;
    logic                 spi_rd_op_q, spi_rd_op_d;
    logic [ADDR_SIZE-1:0] spi_data_q, spi_data_d;
    logic                 spi_ovf_q, spi_ovf_d;
    logic                 last_grant_q, last_grant_d;
    logic [ADDR_SIZE-1:0] host_addr_q, host_addr_d;
    logic [ADDR_SIZE-1:0] host_wdata_q, host_wdata_d;
    logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;

    logic                 accept;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 spi_wins;

    // Addresses wrap within the memory's power-of-two span.
    function automatic logic [ADDR_SIZE-1:0] fit_addr(input logic [ADDR_SIZE-1:0] a);
        return a & ADDR_MASK;
    endfunction

    assign accept  = rx_valid & ~rx_prev_q;
    assign cmd     = rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign payload = rx_data[ADDR_SIZE-1:0];

    always_comb begin
        state_d      = state_q;
        rx_prev_d    = rx_valid;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        spi_pend_d   = spi_pend_q;
        spi_rd_op_d  = spi_rd_op_q;
        spi_data_d   = spi_data_q;
        spi_ovf_d    = spi_ovf_q;
        last_grant_d = last_grant_q;
        host_addr_d  = host_addr_q;
        host_wdata_d = host_wdata_q;
        tx_data_d    = tx_data_q;
        tx_cnt_d     = (tx_cnt_q != '0) ? tx_cnt_q - CNT_W'(1) : '0;
        spi_wins     = 1'b0;
        host_gnt     = 1'b0;
        host_rdata   = '0;
        host_rvalid  = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                // On a tie the side that was not served last goes first.
                spi_wins = spi_pend_q && (!host_req || (last_grant_q == GRANT_HOST));
                if (spi_wins) begin
                    state_d      = spi_rd_op_q ? SPI_RD : SPI_WR;
                    last_grant_d = GRANT_SPI;
                end else if (host_req) begin
                    host_gnt     = 1'b1;
                    state_d      = host_we ? HOST_WR : HOST_RD;
                    host_addr_d  = host_addr;
                    host_wdata_d = host_wdata;
                    last_grant_d = GRANT_HOST;
                end
            end
            SPI_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = fit_addr(wr_addr_q);
                mem_wdata  = spi_data_q;
                spi_pend_d = 1'b0;
                state_d    = IDLE;
            end
            SPI_RD: begin
                mem_en     = 1'b1;
                mem_addr   = fit_addr(rd_addr_q);
                spi_pend_d = 1'b0;
                state_d    = SPI_RDWAIT;
            end
            SPI_RDWAIT: begin
                tx_data_d = mem_rdata;
                tx_cnt_d  = CNT_W'(TX_BEATS);
                if (tx_cnt_q != '0) begin
                    spi_ovf_d = 1'b1;
                end
                state_d = IDLE;
            end
            HOST_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fit_addr(host_addr_q);
                mem_wdata = host_wdata_q;
                state_d   = IDLE;
            end
            HOST_RD: begin
                mem_en   = 1'b1;
                mem_addr = fit_addr(host_addr_q);
                state_d  = HOST_RDWAIT;
            end
            HOST_RDWAIT: begin
                host_rdata  = mem_rdata;
                host_rvalid = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pending SPI access is still pending during its own SPI_WR/SPI_RD cycle,
        // so a memory command arriving then is dropped as an overflow.
        if (accept) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = payload;
                CMD_RD_ADDR: rd_addr_d = payload;
                CMD_WRITE, CMD_READ: begin
                    if (spi_pend_q) begin
                        spi_ovf_d = 1'b1;
                    end else begin
                        spi_pend_d  = 1'b1;
                        spi_rd_op_d = (cmd == CMD_READ);
                        if (cmd == CMD_WRITE) begin
                            spi_data_d = payload;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_prev_q    <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            spi_pend_q   <= 1'b0;
            spi_rd_op_q  <= 1'b0;
            spi_data_q   <= '0;
            spi_ovf_q    <= 1'b0;
            last_grant_q <= GRANT_HOST;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            tx_data_q    <= '0;
            tx_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            rx_prev_q    <= rx_prev_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            spi_pend_q   <= spi_pend_d;
            spi_rd_op_q  <= spi_rd_op_d;
            spi_data_q   <= spi_data_d;
            spi_ovf_q    <= spi_ovf_d;
            last_grant_q <= last_grant_d;
            host_addr_q  <= host_addr_d;
            host_wdata_q <= host_wdata_d;
            tx_data_q    <= tx_data_d;
            tx_cnt_q     <= tx_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = (tx_cnt_q != '0);
    assign spi_ovf  = spi_ovf_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: directed scenarios plus randomized SPI/host traffic
// checked against an array model of the memory contents.
module tb_spi_mem_arbiter;

    localparam int TX = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       spi_ovf;

    spi_mem_arbiter #(.ADDR_SIZE(8), .MEM_DEPTH(256), .TX_BEATS(TX)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .spi_ovf(spi_ovf)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory attached to the DUT.
    logic       mem_clr;
    logic [7:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    // Event counters; the stimulus takes snapshots and compares differences.
    int         wr_cnt;
    int         tx_cyc;
    int         gnt_cyc;
    logic [7:0] last_wa;
    logic [7:0] last_wd;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (tx_valid) tx_cyc <= tx_cyc + 1;
        if (host_gnt) gnt_cyc <= gnt_cyc + 1;
    end

    // Reference model state.
    logic [7:0] ref_mem [256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl, input int hold);
        rx_data  = {cmd, pl};
        rx_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                               output logic [7:0] rd);
        logic got;
        got = 1'b0;
        rd = 8'h00;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (host_gnt) got = 1'b1;
            @(posedge clk); #1;
        end
        host_req = 1'b0;
        check("host_gnt_seen", got, 1);
        if (!we) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (host_rvalid) begin got = 1'b1; rd = host_rdata; end
                @(posedge clk); #1;
            end
            check("host_rvalid_seen", got, 1);
        end
    endtask

    task automatic spi_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        int w0;
        w0 = wr_cnt;
        send_frame(2'b00, a, hold);
        send_frame(2'b01, d, hold);
        wait_cycles(4);
        m_wr_addr = a;
        ref_mem[m_wr_addr] = d;
        check("spi_write_count", wr_cnt - w0, 1);
    endtask

    task automatic spi_read(input logic [7:0] a, input int hold);
        int t0;
        t0 = tx_cyc;
        send_frame(2'b10, a, hold);
        send_frame(2'b11, 8'($urandom_range(0, 255)), hold);
        wait_cycles(TX + 6);
        m_rd_addr = a;
        check("spi_read_tx_data", tx_data, ref_mem[m_rd_addr]);
        check("spi_read_tx_beats", tx_cyc - t0, TX);
        check("spi_read_tx_done", tx_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int         w0;
    int         g0;
    int         t0;
    int         bad;
    logic       found;
    logic [7:0] rd;
    logic [7:0] ra;
    logic [7:0] rdat;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; mem_clr = 1'b1;
        rx_data = '0; rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        m_wr_addr = 8'h00; m_rd_addr = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_spi_ovf", spi_ovf, 0);
        @(posedge clk); #1;
        mem_clr = 1'b0; rst_n = 1'b1;
        wait_cycles(2);

        // Simultaneous SPI and host requests right after reset: SPI first, then host.
        send_frame(2'b00, 8'h21, 1);
        w0 = wr_cnt; g0 = gnt_cyc;
        rx_data = {2'b01, 8'h5A}; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h22; host_wdata = 8'hA5;
        @(negedge clk);
        check("conflict_host_waits", host_gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("conflict_spi_first", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h21, 8'h5A});
        @(posedge clk); #1;
        @(negedge clk);
        check("conflict_host_second", host_gnt, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
        wait_cycles(3);
        check("conflict_gnt_pulses", gnt_cyc - g0, 1);
        check("conflict_write_count", wr_cnt - w0, 2);
        ref_mem[8'h21] = 8'h5A;
        ref_mem[8'h22] = 8'hA5;

        // Write 0xAB to 0x12 over SPI.
        spi_write(8'h12, 8'hAB, 1);
        check("wr12_addr", last_wa, 8'h12);
        check("wr12_data", last_wd, 8'hAB);

        // Read it back: tx_data 0xAB for exactly TX beats.
        spi_read(8'h12, 1);

        // A long-held rx_valid level must produce one write only.
        spi_write(8'h40, 8'h55, 20);
        check("held_level_data", last_wd, 8'h55);

        // Second write command arrives while the first waits behind a host read.
        send_frame(2'b00, 8'h77, 1);
        w0 = wr_cnt;
        rx_data = {2'b01, 8'h3C}; rx_valid = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
        @(negedge clk);
        check("ovf_host_gnt", host_gnt, 1);
        @(posedge clk); #1;
        host_req = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
        rx_data = {2'b01, 8'hC3}; rx_valid = 1'b1;
        @(negedge clk);
        check("ovf_host_rvalid", host_rvalid, 1);
        check("ovf_host_rdata", host_rdata, ref_mem[8'h12]);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("ovf_sticky_set", spi_ovf, 1);
        wait_cycles(5);
        check("ovf_write_count", wr_cnt - w0, 1);
        check("ovf_write_addr", last_wa, 8'h77);
        check("ovf_write_data", last_wd, 8'h3C);
        ref_mem[8'h77] = 8'h3C;
        check("ovf_still_set", spi_ovf, 1);

        // Reset asserted while the SPI read is on the memory bus.
        send_frame(2'b10, 8'h22, 1);
        t0 = tx_cyc;
        rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_en === 1'b1 && mem_we === 1'b0) found = 1'b1;
        end
        check("midrst_saw_spi_rd", found, 1);
        rst_n = 1'b0;
        #1;
        rx_valid = 1'b0;
        check("midrst_mem_en", mem_en, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_spi_ovf", spi_ovf, 0);
        check("midrst_host_rvalid", host_rvalid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_wr_addr = 8'h00; m_rd_addr = 8'h00;
        w0 = wr_cnt;
        wait_cycles(15);
        check("midrst_no_tx", tx_cyc - t0, 0);
        check("midrst_no_write", wr_cnt - w0, 0);
        spi_read(8'h77, 1);

        // Randomized serial traffic from both sides.
        for (int n = 0; n < 40; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rdat = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: spi_write(ra, rdat, int'($urandom_range(1, 3)));
                1: spi_read(ra, int'($urandom_range(1, 3)));
                2: begin
                    host_access(1'b1, ra, rdat, rd);
                    ref_mem[ra] = rdat;
                    wait_cycles(2);
                end
                default: begin
                    host_access(1'b0, ra, 8'h00, rd);
                    check("rand_host_rdata", rd, ref_mem[ra]);
                    wait_cycles(1);
                end
            endcase
        end
        check("rand_no_ovf", spi_ovf, 0);

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (env_mem[i] !== ref_mem[i]) bad++;
        end
        check("final_memory_image_mismatches", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
